// File: rtl/graphics_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : graphics_bus_master
//  Purpose  : Pushes the ten game-state words into the Graphics ASIC buffer
//             registers over the shared 16-bit tri-state databus, optionally
//             reads them back and flags the first masked mismatch.
//  Revision : 1.0 - initial release
// ============================================================================
module graphics_bus_master #(
    parameter logic       VERIFY   = 1'b1,
    parameter logic [9:0] CMP_MASK = 10'h27F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] paddle_1_x,
    input  logic [15:0] paddle_1_y,
    input  logic [15:0] paddle_2_x,
    input  logic [15:0] paddle_2_y,
    input  logic [15:0] ball_x,
    input  logic [15:0] ball_y,
    input  logic [15:0] ball_z,
    input  logic [15:0] p1_score,
    input  logic [15:0] p2_score,
    input  logic [15:0] game_state,
    output logic        chipselect,
    output logic        read,
    output logic [3:0]  data_address,
    inout  wire logic [15:0] databus,
    output logic        busy,
    output logic        done,
    output logic        mismatch,
    output logic [3:0]  mismatch_addr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_TURN  = 3'd2,
        ST_READ  = 3'd3,
        ST_LAST  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] c_last_idx = 4'd9;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic        w_load;

    logic [15:0] r_shadow [0:9];
    logic [15:0] w_snap   [0:9];
    logic [15:0] w_dout_nxt;

    logic        r_cs;
    logic        r_read;
    logic [3:0]  r_addr;
    logic        r_oe;
    logic [15:0] r_dout;
    logic        r_busy;
    logic        r_done;
    logic        r_mismatch;
    logic [3:0]  r_mismatch_addr;

    logic        w_cmp_en;
    logic [3:0]  w_cmp_addr;
    logic        w_cmp_fail;

    assign w_snap[0] = paddle_1_x;
    assign w_snap[1] = paddle_1_y;
    assign w_snap[2] = paddle_2_x;
    assign w_snap[3] = paddle_2_y;
    assign w_snap[4] = ball_x;
    assign w_snap[5] = ball_y;
    assign w_snap[6] = ball_z;
    assign w_snap[7] = p1_score;
    assign w_snap[8] = p2_score;
    assign w_snap[9] = game_state;

    // State and index register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state, index sequencing and snapshot request
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (r_idx == c_last_idx) begin
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = VERIFY ? ST_TURN : ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            ST_TURN: begin
                w_idx_nxt   = 4'd0;
                w_state_nxt = ST_READ;
            end
            ST_READ: begin
                if (r_idx == c_last_idx) begin
                    w_state_nxt = ST_LAST;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            ST_LAST: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so the compare target is idx-1
    // during READ and address 9 during LAST
    always_comb begin
        w_cmp_en   = 1'b0;
        w_cmp_addr = 4'd0;
        if (r_state == ST_READ && r_idx != 4'd0) begin
            w_cmp_en   = 1'b1;
            w_cmp_addr = r_idx - 4'd1;
        end else if (r_state == ST_LAST) begin
            w_cmp_en   = 1'b1;
            w_cmp_addr = c_last_idx;
        end
        w_cmp_fail = w_cmp_en && CMP_MASK[w_cmp_addr] &&
                     (databus != r_shadow[w_cmp_addr]);
    end

    // Word for the next cycle; on the snapshot edge the shadows are not yet loaded
    always_comb begin
        w_dout_nxt = w_load ? w_snap[w_idx_nxt] : r_shadow[w_idx_nxt];
    end

    // Shadow registers capture all inputs when a transfer is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 10; i++) r_shadow[i] <= 16'd0;
        end else if (w_load) begin
            for (int i = 0; i < 10; i++) r_shadow[i] <= w_snap[i];
        end
    end

    // Bus outputs registered from the upcoming state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs   <= 1'b0;
            r_read <= 1'b0;
            r_addr <= 4'd0;
            r_oe   <= 1'b0;
            r_dout <= 16'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_cs   <= (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_READ);
            r_read <= (w_state_nxt == ST_READ);
            r_addr <= ((w_state_nxt == ST_WRITE) || (w_state_nxt == ST_READ)) ? w_idx_nxt : 4'd0;
            r_oe   <= (w_state_nxt == ST_WRITE);
            r_dout <= w_dout_nxt;
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    // Sticky mismatch flag with first-failure address, cleared on a new transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mismatch      <= 1'b0;
            r_mismatch_addr <= 4'd0;
        end else if (w_load) begin
            r_mismatch      <= 1'b0;
            r_mismatch_addr <= 4'd0;
        end else if (w_cmp_fail && !r_mismatch) begin
            r_mismatch      <= 1'b1;
            r_mismatch_addr <= w_cmp_addr;
        end
    end

    assign chipselect    = r_cs;
    assign read          = r_read;
    assign data_address  = r_addr;
    assign busy          = r_busy;
    assign done          = r_done;
    assign mismatch      = r_mismatch;
    assign mismatch_addr = r_mismatch_addr;
    assign databus       = r_oe ? r_dout : 16'hzzzz;

endmodule
`default_nettype wire

// File: doc/graphics_bus_master.md
# graphics_bus_master

Bus initiator that pushes the ten game-state words (paddle 1/2 x,y; ball x,y,z; p1/p2 score; game state) into the Graphics ASIC's buffer registers over the shared 16-bit tri-state databus. It optionally reads all ten registers back and flags any mismatch. It sits between the game-logic core and the Graphics ASIC chipselect/read/data_address/databus port, and runs one complete transfer per `start` request (normally once per frame).

## Interface
- `VERIFY`, 1: 1 = perform a read-back pass after writing; 0 = write only.
- `CMP_MASK`, 10'h27F: bit k=1 compares address k on read-back. Addresses 7 and 8 (scores) are excluded by default because the responder may zero them.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: transfer request; sampled only in IDLE.
- `paddle_1_x`, `paddle_1_y`, `paddle_2_x`, `paddle_2_y` in 16 each: paddle positions; written to addresses 0–3.
- `ball_x`, `ball_y`, `ball_z` in 16 each: ball position; written to addresses 4–6.
- `p1_score`, `p2_score`, `game_state` in 16 each: written to addresses 7–9.
- `chipselect` out 1: bus select to the ASIC.
- `read` out 1: 1 = read cycle, 0 = write cycle (meaningful only while `chipselect`=1).
- `data_address` out 4: register index, 0–9.
- `databus` inout 16: driven by this block only in WRITE; otherwise 16'hzzzz.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `mismatch` out 1: sticky; set on any compared mismatch, cleared at the next accepted `start`.
- `mismatch_addr` out 4: address of the first mismatch in the current transfer; 0 when none.

## Operation
- All bus outputs are registered. `databus` drives from a registered data word plus a registered output-enable.
- On accepted `start`, all ten inputs are snapshotted into shadow registers. Input changes during the transfer have no effect.
- Index counter `idx` (4 bits) runs 0..9 and never exceeds 9.
- States:
  - IDLE: `chipselect`=0, bus released. `start`=1 → snapshot, `idx`=0, clear `mismatch`/`mismatch_addr` → WRITE.
  - WRITE: `chipselect`=1, `read`=0, `data_address`=`idx`, `databus`=shadow[`idx`]. When `idx`==9: go to TURN if `VERIFY`, otherwise DONE. Else `idx`+1.
  - TURN: one cycle, `chipselect`=0, bus released (turnaround). Then `idx`=0 → READ.
  - READ: `chipselect`=1, `read`=1, `data_address`=`idx`. The responder returns data one cycle later, so in every READ cycle with `idx`>0 the block samples `databus` as the data for `idx`−1 and compares. When `idx`==9 → LAST.
  - LAST: `chipselect`=0; sample and compare the data for address 9 → DONE.
  - DONE: `done`=1 for one cycle, bus released → IDLE.
- Compare rule: a mismatch is counted only if `CMP_MASK`[a]=1 and the sampled word ≠ shadow[a]. On the first mismatch, set `mismatch` and latch `mismatch_addr`=a. Later mismatches do not change `mismatch_addr`.
- `start` outside IDLE is ignored; it is not queued.

## Timing
- Reset (async, `rst`=0): state IDLE, `chipselect`=0, `read`=0, `data_address`=0, `databus`=z, `busy`=0, `done`=0, `mismatch`=0, `mismatch_addr`=0, shadows=0. Reset takes effect immediately, mid-transfer included, and the bus is released at once.
- `start` sampled high at edge E0: the first WRITE cycle follows E0. Address k is presented in cycle k+1.
- Write-only: `done` is high in cycle 11 after E0; `busy` is high in cycles 1–11.
- Verify: WRITE in cycles 1–10, TURN in 11, READ in 12–21, LAST in 22, `done` in 23. `mismatch` is final in the `done` cycle.
- The earliest next `start` is sampled in the IDLE cycle following `done`. Minimum period is 12 cycles (write-only) or 24 cycles (verify).
- The block never drives `databus` in the cycle immediately after a READ or LAST cycle.

## Test plan
- Write-only (`VERIFY`=0), inputs 320/240/320/240/100/200/500/3/4/0, bench responder model → writes observed at addresses 0..9 in cycles 1..10 with exactly those values; `done` pulse in cycle 11; `databus`=z in every other cycle.
- Verify pass, same values, model returns stored data → 10 reads in cycles 12–21, `done` in cycle 23, `mismatch`=0, `mismatch_addr`=0.
- Fault injection: model forces bit 0 high on read of address 3 (and of address 5) → `mismatch`=1, `mismatch_addr`=3; a subsequent `start` clears both.
- Score masking: `game_state`=1 and model returns 0 for addresses 7/8 with default `CMP_MASK` → `mismatch`=0. With `CMP_MASK`=10'h3FF and `p1_score`=3 → `mismatch_addr`=7.
- `start` held high continuously and pulsed during WRITE → exactly one transfer per IDLE visit. Inputs changed mid-transfer → the old snapshot values appear on the bus.
- `rst` asserted low in cycle 5 (during WRITE) → `chipselect`=0, `databus`=z, `busy`=0 before the next edge. After release, a new `start` restarts the transfer at address 0.
